// File: rtl/bus_pack_pkg.sv
// Shared definitions for the bus pack register: byte width and the
// width helpers used to size the select/size fields.
package bus_pack_pkg;

   localparam int byte_width_lp = 8;

   // clog2 that never returns 0, so a 1-byte bus still gets a 1-bit select
   function automatic int safe_clog2_f(input int value);
      return (value <= 1) ? 1 : $clog2(value);
   endfunction

   // Bits needed to hold the value of the byte-offset width (largest legal log2 size)
   function automatic int size_width_f(input int byte_offset_width);
      return safe_clog2_f(byte_offset_width + 1);
   endfunction

endpackage

// File: rtl/bus_pack_reg_if.sv
// Bus bundle for bus_pack_reg: capture request (en/sel/size), live input
// data, and the packed output with the registered select/size.
interface bus_pack_reg_if
   import bus_pack_pkg::*;
#(
   parameter int in_width_p  = 32,
   parameter int out_width_p = 64
);

   localparam int byte_offset_width_lp = safe_clog2_f(in_width_p / byte_width_lp);
   localparam int size_width_lp        = size_width_f(byte_offset_width_lp);

   logic                            en;
   logic [byte_offset_width_lp-1:0] sel;
   logic [size_width_lp-1:0]        size;
   logic [in_width_p-1:0]           data;
   logic [out_width_p-1:0]          packed_data;
   logic [byte_offset_width_lp-1:0] sel_q;
   logic [size_width_lp-1:0]        size_q;

   modport master (
      output en, sel, size, data,
      input  packed_data, sel_q, size_q
   );

   modport slave (
      input  en, sel, size, data,
      output packed_data, sel_q, size_q
   );

endinterface

// File: rtl/bsg_dff_reset_en.sv
// Enable-and-reset flop: reset wins over enable, otherwise load on enable
// and hold when disabled.
module bsg_dff_reset_en #(
   parameter int width_p = 1
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               en_i,
   input  logic [width_p-1:0] data_i,
   output logic [width_p-1:0] data_o
);

   logic [width_p-1:0] data_r;

   // Synchronous reset has priority over a simultaneous load
   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      if (reset_i)
         data_r <= '0;
      else if (en_i)
         data_r <= data_i;
   end

   assign data_o = data_r;

endmodule

// File: rtl/bus_pack_reg.sv
// Bus pack register: registers a byte select and log2 slice size, then
// combinationally extracts that slice from the live input bus and
// replicates it across the output bus. Bytes beyond the top of the input
// read as zero; sizes beyond the input width use the whole shifted bus.
// Optional simulation checks: define BUS_PACK_REG_ASSERT_EN.
module bus_pack_reg
   import bus_pack_pkg::*;
#(
   parameter int in_width_p  = 32,
   parameter int out_width_p = 64
) (
   input  logic           clk_i,
   input  logic           reset_i,
   bus_pack_reg_if.slave  bus
);

   localparam int byte_offset_width_lp = safe_clog2_f(in_width_p / byte_width_lp);
   localparam int size_width_lp        = size_width_f(byte_offset_width_lp);
   localparam int max_size_lp          = $clog2(in_width_p / byte_width_lp);

   logic [byte_offset_width_lp-1:0] sel_r;
   logic [size_width_lp-1:0]        size_r;
   logic [in_width_p-1:0]           shifted;
   logic [out_width_p-1:0]          slice_rep [max_size_lp+1];
   logic [out_width_p-1:0]          packed_data;

   bsg_dff_reset_en #(
      .width_p (size_width_lp + byte_offset_width_lp)
   ) capture_reg (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .en_i    (bus.en),
      .data_i  ({bus.size, bus.sel}),
      .data_o  ({size_r, sel_r})
   );

   // Logical shift zero-fills bytes above the top of the input bus
   assign shifted = bus.data >> {sel_r, 3'b000};

   // One replicated candidate per legal slice size
   for (genvar i = 0; i <= max_size_lp; i++) begin : g_size
      assign slice_rep[i] =
         {(out_width_p / (byte_width_lp << i)){shifted[(byte_width_lp << i)-1:0]}};
   end

   // Pick the candidate for the registered size; oversized falls back to full width
   always_comb begin
      // NOTE: default first so every path assigns and no latch is inferred.
      packed_data = slice_rep[max_size_lp];
      for (int i = 0; i <= max_size_lp; i++) begin
         if (size_r == size_width_lp'(i))
            packed_data = slice_rep[i];
      end
   end

   assign bus.packed_data = packed_data;
   assign bus.sel_q       = sel_r;
   assign bus.size_q      = size_r;

`ifdef BUS_PACK_REG_ASSERT_EN
   // Flag illegal parameters and out-of-range captures every cycle out of reset
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         assert (out_width_p >= in_width_p)
            else $error("bus_pack_reg: out_width_p %0d < in_width_p %0d", out_width_p, in_width_p);
         assert (((in_width_p & (in_width_p - 1)) == 0) && ((out_width_p & (out_width_p - 1)) == 0)
                 && (in_width_p >= byte_width_lp))
            else $error("bus_pack_reg: widths %0d/%0d not powers of two", in_width_p, out_width_p);
         if (bus.en) begin
            assert (int'(bus.size) <= max_size_lp)
               else $error("bus_pack_reg: capture size %0d exceeds %0d", bus.size, max_size_lp);
            assert (int'(bus.sel) + (1 << int'(bus.size)) <= in_width_p / byte_width_lp)
               else $error("bus_pack_reg: capture sel %0d size %0d runs past the bus", bus.sel, bus.size);
         end
      end
   end
`endif

endmodule

// File: tb/tb_bus_pack_reg.sv
// Directed plus short random bench for bus_pack_reg (32-bit in, 64-bit out).
// Expected values are queued when stimulus is driven and popped at sampling.
module tb_bus_pack_reg;

   localparam int in_w  = 32;
   localparam int out_w = 64;

   typedef struct {
      string       tag;
      logic [63:0] data;
      logic [1:0]  sel;
      logic [1:0]  size;
   } exp_t;

   logic clk;
   logic reset;
   exp_t sb_q[$];
   int   checks;
   int   passed;

   bus_pack_reg_if #(.in_width_p(in_w), .out_width_p(out_w)) bus ();

   bus_pack_reg #(.in_width_p(in_w), .out_width_p(out_w)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit expired, actual=running required=finished");
      $fatal(1, "watchdog");
   end

   // Byte-wise reference: zero-filled shift, clamp size, replicate slice
   function automatic logic [63:0] model(input logic [31:0] d, input int sel, input int size);
      logic [7:0]  b [4];
      logic [63:0] r;
      int          nbytes;
      for (int j = 0; j < 4; j++)
         b[j] = (j + sel < 4) ? d[8*(j+sel) +: 8] : 8'h00;
      nbytes = 1 << ((size > 2) ? 2 : size);
      r = '0;
      for (int k = 0; k < 8; k++)
         r[8*k +: 8] = b[k % nbytes];
      return r;
   endfunction

   task automatic compare();
      exp_t e;
      if (sb_q.size() == 0) begin
         checks++;
         $error("FAIL scoreboard_empty: actual=0 entries required=1");
         return;
      end
      e = sb_q.pop_front();
      checks++;
      assert (bus.packed_data === e.data) passed++;
      else $error("FAIL %s data: actual=%h required=%h", e.tag, bus.packed_data, e.data);
      checks++;
      assert (bus.sel_q === e.sel) passed++;
      else $error("FAIL %s sel: actual=%0d required=%0d", e.tag, bus.sel_q, e.sel);
      checks++;
      assert (bus.size_q === e.size) passed++;
      else $error("FAIL %s size: actual=%0d required=%0d", e.tag, bus.size_q, e.size);
   endtask

   // Drive one cycle of stimulus, queue expectation, clock it, sample on the falling edge
   task automatic step(input string tag, input logic rst, input logic en,
                       input logic [1:0] sel, input logic [1:0] size, input logic [31:0] data,
                       input logic [63:0] exp_data, input logic [1:0] exp_sel,
                       input logic [1:0] exp_size);
      exp_t e;
      reset    = rst;
      bus.en   = en;
      bus.sel  = sel;
      bus.size = size;
      bus.data = data;
      e.tag = tag; e.data = exp_data; e.sel = exp_sel; e.size = exp_size;
      sb_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      compare();
   endtask

   initial begin
      logic [1:0]  rs;
      logic [1:0]  rz;
      logic [1:0]  cur_sel;
      logic [1:0]  cur_size;
      logic [31:0] rd;
      exp_t        e;
      checks = 0;
      passed = 0;
      reset = 1'b1; bus.en = 1'b0; bus.sel = '0; bus.size = '0; bus.data = 32'hAABBCCDD;
      @(negedge clk);

      step("reset",      1, 0, 2'd0, 2'd0, 32'hAABBCCDD, 64'hDDDDDDDDDDDDDDDD, 2'd0, 2'd0);
      step("idle",       0, 0, 2'd0, 2'd0, 32'hAABBCCDD, 64'hDDDDDDDDDDDDDDDD, 2'd0, 2'd0);
      step("word",       0, 1, 2'd0, 2'd2, 32'hAABBCCDD, 64'hAABBCCDDAABBCCDD, 2'd0, 2'd2);
      step("half_hi",    0, 1, 2'd2, 2'd1, 32'hAABBCCDD, 64'hAABBAABBAABBAABB, 2'd2, 2'd1);

      // Same-cycle response to a new data bus with no capture
      bus.en = 1'b0; bus.data = 32'h11223344;
      e.tag = "live_data"; e.data = 64'h1122112211221122; e.sel = 2'd2; e.size = 2'd1;
      sb_q.push_back(e);
      #1;
      compare();
      @(negedge clk);

      step("byte1",      0, 1, 2'd1, 2'd0, 32'hAABBCCDD, 64'hCCCCCCCCCCCCCCCC, 2'd1, 2'd0);
      step("hold",       0, 0, 2'd3, 2'd1, 32'hAABBCCDD, 64'hCCCCCCCCCCCCCCCC, 2'd1, 2'd0);
      step("reset_en",   1, 1, 2'd3, 2'd1, 32'hAABBCCDD, 64'hDDDDDDDDDDDDDDDD, 2'd0, 2'd0);
      step("misaligned", 0, 1, 2'd3, 2'd1, 32'hAABBCCDD, 64'h00AA00AA00AA00AA, 2'd3, 2'd1);
      step("oversize",   0, 1, 2'd1, 2'd3, 32'hAABBCCDD, 64'h00AABBCC00AABBCC, 2'd1, 2'd3);
      step("word_off3",  0, 1, 2'd3, 2'd2, 32'hAABBCCDD, 64'h000000AA000000AA, 2'd3, 2'd2);

      // Random captures and holds against the byte-wise model
      cur_sel = 2'd3; cur_size = 2'd2;
      for (int i = 0; i < 12; i++) begin
         logic en;
         rs = 2'($urandom_range(0, 3));
         rz = 2'($urandom_range(0, 3));
         rd = $urandom;
         en = 1'($urandom_range(0, 1));
         if (en) begin
            cur_sel  = rs;
            cur_size = rz;
         end
         step("random", 0, en, rs, rz, rd, model(rd, int'(cur_sel), int'(cur_size)), cur_sel, cur_size);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
